stopwatch_ctrl: RTL and testbench

Front-panel controller that sequences the 3-digit BCD stopwatch core. It converts two debounced push-button levels into the core's go/clr controls and runs a start/pause/split/clear state machine. It freezes a split ("lap") reading on the display, counts laps, and flags counter wrap-around. It sits between the button debouncers and the stopwatch core/display driver.

---
 rtl/stopwatch_ctrl.sv | 151 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Front-panel controller for the 3-digit BCD stopwatch core: button edge
// detection, start/pause/split/clear FSM, split freeze, lap count, overflow.
module stopwatch_ctrl #(
  parameter int unsigned LONG_CYCLES = 2000,
  parameter int unsigned CNT_W       = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic [3:0] d2_in,
  input  logic [3:0] d1_in,
  input  logic [3:0] d0_in,
  output logic       go,
  output logic       clr,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic [1:0] state,
  output logic [3:0] lap_cnt,
  output logic       ovf
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StLap   = 2'b10,
    StPause = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] LongMax = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LongPre = CNT_W'(LONG_CYCLES - 1);

  state_e           state_q, state_d;
  logic             go_q, go_d;
  logic             clr_q, clr_d;
  logic             ss_prev_q, lap_prev_q;
  logic [CNT_W-1:0] lp_cnt_q, lp_cnt_d;
  logic [3:0]       lap_cnt_q, lap_cnt_d;
  logic             ovf_q, ovf_d;
  logic [11:0]      lap_reg_q;
  logic [11:0]      prev_live_q;
  logic [11:0]      live;
  logic             press_ss, press_lap, long_fire, capture;

  assign live      = {d2_in, d1_in, d0_in};
  assign press_ss  = btn_ss & ~ss_prev_q;
  assign press_lap = btn_lap & ~lap_prev_q;
  // Fires only on the cycle the hold count reaches its limit, once per hold.
  assign long_fire = btn_lap & (lp_cnt_q == LongPre);

  // Next-state, capture, clear pulse and sticky-flag logic.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    lp_cnt_d  = lp_cnt_q;
    lap_cnt_d = lap_cnt_q;
    ovf_d     = ovf_q;

    if (!btn_lap) begin
      lp_cnt_d = '0;
    end else if (lp_cnt_q != LongMax) begin
      lp_cnt_d = lp_cnt_q + 1'b1;
    end

    if (long_fire && state_q != StIdle) begin
      state_d = StIdle;
    end else if (press_ss) begin
      unique case (state_q)
        StIdle:  state_d = StRun;
        StRun:   state_d = StPause;
        StLap:   state_d = StPause;
        StPause: state_d = StRun;
        default: state_d = StIdle;
      endcase
    end else if (press_lap) begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StRun: begin
          state_d = StLap;
          capture = 1'b1;
        end
        StLap:   state_d = StRun;
        StPause: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    go_d  = (state_d == StRun) || (state_d == StLap);
    clr_d = (state_q != StIdle) && (state_d == StIdle);

    if (capture && lap_cnt_q != 4'd15) begin
      lap_cnt_d = lap_cnt_q + 4'd1;
    end

    if ((state_q == StRun || state_q == StLap) &&
        prev_live_q == 12'h999 && live == 12'h000) begin
      ovf_d = 1'b1;
    end

    // Clear wins over any increment or overflow set in the same cycle.
    if (clr_d) begin
      lap_cnt_d = '0;
      ovf_d     = 1'b0;
    end
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      go_q        <= 1'b0;
      clr_q       <= 1'b1;
      ss_prev_q   <= 1'b1;
      lap_prev_q  <= 1'b1;
      lp_cnt_q    <= '0;
      lap_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      lap_reg_q   <= '0;
      prev_live_q <= '0;
    end else begin
      state_q     <= state_d;
      go_q        <= go_d;
      clr_q       <= clr_d;
      ss_prev_q   <= btn_ss;
      lap_prev_q  <= btn_lap;
      lp_cnt_q    <= lp_cnt_d;
      lap_cnt_q   <= lap_cnt_d;
      ovf_q       <= ovf_d;
      prev_live_q <= live;
      if (capture) begin
        lap_reg_q <= live;
      end
    end
  end

  // Display shows the frozen split only while in LAP.
  always_comb begin
    {d2, d1, d0} = live;
    if (state_q == StLap) begin
      {d2, d1, d0} = lap_reg_q;
    end
  end

  assign go      = go_q;
  assign clr     = clr_q;
  assign state   = state_q;
  assign lap_cnt = lap_cnt_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_ss, btn_lap;
  logic [3:0] d2_in, d1_in, d0_in;
  logic       go, clr;
  logic [3:0] d2, d1, d0;
  logic [1:0] state;
  logic [3:0] lap_cnt;
  logic       ovf;

  int tests = 0;
  int fails = 0;
  int pulses;

  stopwatch_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .btn_ss  (btn_ss),
    .btn_lap (btn_lap),
    .d2_in   (d2_in),
    .d1_in   (d1_in),
    .d0_in   (d0_in),
    .go      (go),
    .clr     (clr),
    .d2      (d2),
    .d1      (d1),
    .d0      (d0),
    .state   (state),
    .lap_cnt (lap_cnt),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_live(input logic [11:0] v);
    {d2_in, d1_in, d0_in} = v;
  endtask

  // One-cycle press then release; state has updated after the first tick.
  task automatic press_ss();
    btn_ss = 1'b1;
    tick();
    btn_ss = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; btn_ss = 1'b1; btn_lap = 1'b0; set_live(12'h000);
    repeat (3) tick();
    check("rst_clr", clr, 1);
    check("rst_state", state, 0);
    check("rst_go", go, 0);
    check("rst_lap_cnt", lap_cnt, 0);
    check("rst_ovf", ovf, 0);

    // Button held through reset must not start the watch.
    reset = 1'b0;
    tick();
    check("post_rst_clr", clr, 0);
    check("held_ss_idle", state, 0);
    tick();
    check("held_ss_idle2", state, 0);
    btn_ss = 1'b0;
    tick();
    btn_ss = 1'b1;
    tick();
    check("start_state", state, 1);
    check("start_go", go, 1);
    btn_ss = 1'b0;
    set_live(12'h789);
    tick();
    check("run_live", {d2, d1, d0}, 12'h789);
    btn_ss = 1'b1;
    tick();
    check("pause_state", state, 3);
    check("pause_go", go, 0);
    check("pause_live", {d2, d1, d0}, 12'h789);
    btn_ss = 1'b0;
    tick();
    press_ss();
    check("resume_state", state, 1);

    // Split freeze and release.
    set_live(12'h123);
    btn_lap = 1'b1;
    tick();
    check("lap_state", state, 2);
    check("lap_cnt1", lap_cnt, 1);
    btn_lap = 1'b0;
    set_live(12'h456);
    tick();
    check("lap_frozen", {d2, d1, d0}, 12'h123);
    check("lap_go", go, 1);
    btn_lap = 1'b1;
    tick();
    check("unlap_state", state, 1);
    check("unlap_live", {d2, d1, d0}, 12'h456);
    check("unlap_cnt", lap_cnt, 1);
    btn_lap = 1'b0;
    tick();

    // Overflow while running, sticky.
    set_live(12'h999);
    tick();
    set_live(12'h000);
    tick();
    check("ovf_set", ovf, 1);
    set_live(12'h001);
    tick();
    check("ovf_sticky", ovf, 1);

    // Clear from PAUSE.
    press_ss();
    check("pause2_state", state, 3);
    btn_lap = 1'b1;
    tick();
    check("clr_state", state, 0);
    check("clr_pulse", clr, 1);
    check("clr_lap_cnt", lap_cnt, 0);
    check("clr_ovf", ovf, 0);
    btn_lap = 1'b0;
    tick();
    check("clr_one_cycle", clr, 0);
    btn_lap = 1'b1;
    tick();
    check("idle_lap_state", state, 0);
    check("idle_lap_clr", clr, 0);
    btn_lap = 1'b0;
    tick();

    // Wrap in PAUSE leaves ovf alone.
    press_ss();
    press_ss();
    check("pause3_state", state, 3);
    set_live(12'h999);
    tick();
    set_live(12'h000);
    tick();
    check("ovf_pause", ovf, 0);

    // Simultaneous presses in RUN: start/stop wins.
    press_ss();
    check("run3_state", state, 1);
    btn_ss = 1'b1; btn_lap = 1'b1;
    tick();
    check("both_state", state, 3);
    check("both_lap_cnt", lap_cnt, 0);
    btn_ss = 1'b0; btn_lap = 1'b0;
    tick();
    press_ss();
    check("run4_state", state, 1);

    // Long press: RUN -> LAP -> IDLE at hold cycle 2000, single clr pulse.
    btn_lap = 1'b1;
    tick();
    check("long_lap", state, 2);
    check("long_lap_cnt", lap_cnt, 1);
    repeat (1998) tick();
    check("long_pre", state, 2);
    check("long_pre_clr", clr, 0);
    tick();
    check("long_fire_state", state, 0);
    check("long_fire_clr", clr, 1);
    check("long_fire_cnt", lap_cnt, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (clr) pulses++;
    end
    check("long_no_repulse", pulses, 0);
    check("long_hold_state", state, 0);
    btn_lap = 1'b0;
    tick();

    // Lap count saturates at 15.
    press_ss();
    for (int i = 0; i < 16; i++) begin
      btn_lap = 1'b1; tick();
      btn_lap = 1'b0; tick();
      btn_lap = 1'b1; tick();
      btn_lap = 1'b0; tick();
    end
    check("lap_sat", lap_cnt, 15);
    check("lap_sat_state", state, 1);

    // Reset mid-run.
    reset = 1'b1;
    tick();
    check("midrst_state", state, 0);
    check("midrst_go", go, 0);
    check("midrst_clr", clr, 1);
    check("midrst_cnt", lap_cnt, 0);
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
